// File: rtl/i2c_pkg.sv
// i2c_pkg: shared widths and FSM state encoding for the I2C slave controller
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT} state_t;
endpackage

// File: rtl/i2c_slave_ctrl_if.sv
// i2c_slave_ctrl_if: conditioner strobes in, SDA drive and host byte handshake out
interface i2c_slave_ctrl_if;
  import i2c_pkg::*;
  logic sck_rise, sck_fall, sck_high, sda_rise, sda_fall, sda_high;
  logic sda_oe, rx_valid, tx_load, rw, busy, start_det, stop_det;
  logic [BYTE_W-1:0] rx_data, tx_data;
  modport slave (
    input  sck_rise, sck_fall, sck_high, sda_rise, sda_fall, sda_high, tx_data,
    output sda_oe, rx_data, rx_valid, tx_load, rw, busy, start_det, stop_det
  );
  modport master (
    output sck_rise, sck_fall, sck_high, sda_rise, sda_fall, sda_high, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_load, rw, busy, start_det, stop_det
  );
endinterface

// File: rtl/i2c_shift8.sv
// i2c_shift8: byte shifter with parallel load and wrapping 3-bit bit counter
module i2c_shift8
  import i2c_pkg::*;
(
  input  logic              gclk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift,
  input  logic              sin,
  input  logic              load,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] q,
  output logic [2:0]        cnt
);
  always_ff @(posedge gclk or negedge rst_n)
    if (!rst_n) begin
      q <= '0;
      cnt <= '0;
    end else begin
      q <= load ? din : shift ? {q[BYTE_W-2:0], sin} : q;
      cnt <= clr ? 3'd0 : shift ? cnt + 3'd1 : cnt;
    end
endmodule

// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl: byte-level I2C slave FSM (address match, write receive, read transmit)
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic gclk,
  input  logic rst_n,
  i2c_slave_ctrl_if.slave bus
);
  state_t state, state_n;
  logic full, full_n, oe_n, rw_n, rxv_n, txl_n, busy_n, sd_n, pd_n;
  logic shift, load, clr, start, stop;
  logic [BYTE_W-1:0] q, byte_in, rxd_n;
  logic [2:0] cnt;
  i2c_shift8 u_shift (
    .gclk(gclk), .rst_n(rst_n), .clr(clr), .shift(shift), .sin(bus.sda_high),
    .load(load), .din(bus.tx_data), .q(q), .cnt(cnt)
  );
  assign start = bus.sda_fall & bus.sck_high;
  assign stop = bus.sda_rise & bus.sck_high;
  assign byte_in = {q[BYTE_W-2:0], bus.sda_high};
  // full marks a completed byte (or master ACK) awaiting the following SCL fall
  always_comb begin
    state_n = state;
    full_n = full;
    oe_n = bus.sda_oe;
    rw_n = bus.rw;
    rxd_n = bus.rx_data;
    busy_n = bus.busy;
    rxv_n = 1'b0;
    txl_n = 1'b0;
    sd_n = 1'b0;
    pd_n = 1'b0;
    shift = 1'b0;
    load = 1'b0;
    clr = 1'b0;
    if (start) begin
      state_n = ADDR;
      clr = 1'b1;
      oe_n = 1'b0;
      sd_n = 1'b1;
      busy_n = 1'b1;
      full_n = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      oe_n = 1'b0;
      pd_n = 1'b1;
      busy_n = 1'b0;
      full_n = 1'b0;
    end else
      case (state)
        ADDR:
          if (bus.sck_rise) begin
            shift = 1'b1;
            if (cnt == 3'd7) begin
              if (byte_in[BYTE_W-1:1] == SLAVE_ADDR) begin
                rw_n = byte_in[0];
                full_n = 1'b1;
              end else state_n = WAIT;
            end
          end else if (bus.sck_fall && full) begin
            oe_n = 1'b1;
            full_n = 1'b0;
            state_n = ADDR_ACK;
          end
        ADDR_ACK:
          if (bus.sck_fall) begin
            load = bus.rw;
            txl_n = bus.rw;
            oe_n = bus.rw & ~bus.tx_data[BYTE_W-1];
            state_n = bus.rw ? TX : RX;
          end
        RX:
          if (bus.sck_rise) begin
            shift = 1'b1;
            if (cnt == 3'd7) begin
              rxd_n = byte_in;
              rxv_n = 1'b1;
              full_n = 1'b1;
            end
          end else if (bus.sck_fall && full) begin
            oe_n = 1'b1;
            full_n = 1'b0;
            state_n = RX_ACK;
          end
        RX_ACK:
          if (bus.sck_fall) begin
            oe_n = 1'b0;
            state_n = RX;
          end
        // own SDA is shifted back in on each rise so q[7] always holds the next bit
        TX:
          if (bus.sck_rise) begin
            shift = 1'b1;
            full_n = cnt == 3'd7;
          end else if (bus.sck_fall) begin
            oe_n = ~full & ~q[BYTE_W-1];
            full_n = 1'b0;
            state_n = full ? TX_ACK : TX;
          end
        TX_ACK:
          if (bus.sck_rise) begin
            state_n = bus.sda_high ? WAIT : TX_ACK;
            full_n = ~bus.sda_high;
          end else if (bus.sck_fall && full) begin
            load = 1'b1;
            txl_n = 1'b1;
            oe_n = ~bus.tx_data[BYTE_W-1];
            full_n = 1'b0;
            state_n = TX;
          end
        default: ;
      endcase
  end
  always_ff @(posedge gclk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      full <= 1'b0;
      bus.sda_oe <= 1'b0;
      bus.rx_data <= '0;
      bus.rx_valid <= 1'b0;
      bus.tx_load <= 1'b0;
      bus.rw <= 1'b0;
      bus.busy <= 1'b0;
      bus.start_det <= 1'b0;
      bus.stop_det <= 1'b0;
    end else begin
      state <= state_n;
      full <= full_n;
      bus.sda_oe <= oe_n;
      bus.rx_data <= rxd_n;
      bus.rx_valid <= rxv_n;
      bus.tx_load <= txl_n;
      bus.rw <= rw_n;
      bus.busy <= busy_n;
      bus.start_det <= sd_n;
      bus.stop_det <= pd_n;
    end
endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb_i2c_slave_ctrl: directed I2C master plus conditioner model driving i2c_slave_ctrl
module tb_i2c_slave_ctrl;
  import i2c_pkg::*;
  localparam int H = 20;
  logic gclk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1, sda_m = 1'b1;
  logic scl_d = 1'b1, scl_q = 1'b1, sda_d = 1'b1, sda_q = 1'b1;
  logic sda_line;
  int total = 0, bad = 0, cyc = 0;
  int rxv_cnt = 0, txl_cnt = 0, sd_cnt = 0, pd_cnt = 0, oe_cnt = 0;
  logic [7:0] rx_log [0:63];
  int rxv_cyc [0:63];
  i2c_slave_ctrl_if bus ();
  i2c_slave_ctrl #(.SLAVE_ADDR(7'h50)) dut (.gclk(gclk), .rst_n(rst_n), .bus(bus));
  always #5 gclk = ~gclk;
  assign sda_line = sda_m & ~bus.sda_oe;
  always @(posedge gclk) begin
    scl_d <= scl;
    scl_q <= scl_d;
    sda_d <= sda_line;
    sda_q <= sda_d;
  end
  assign bus.sck_rise = scl_d & ~scl_q;
  assign bus.sck_fall = ~scl_d & scl_q;
  assign bus.sck_high = scl_d & scl_q;
  assign bus.sda_rise = sda_d & ~sda_q;
  assign bus.sda_fall = ~sda_d & sda_q;
  assign bus.sda_high = sda_d & sda_q;
  always @(negedge gclk) begin
    cyc++;
    if (bus.rx_valid) begin
      rx_log[rxv_cnt] = bus.rx_data;
      rxv_cyc[rxv_cnt] = cyc;
      rxv_cnt++;
    end
    if (bus.tx_load) txl_cnt++;
    if (bus.start_det) sd_cnt++;
    if (bus.stop_det) pd_cnt++;
    if (bus.sda_oe) oe_cnt++;
  end
  task automatic hold(input int n);
    repeat (n) @(posedge gclk);
    #1;
  endtask
  task automatic clk_bit(input logic b, output logic line, output logic oe);
    hold(H/2);
    sda_m = b;
    hold(H/2);
    scl = 1'b1;
    hold(H/2);
    line = sda_line;
    oe = bus.sda_oe;
    hold(H/2);
    scl = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] v, output logic ack_oe);
    logic l, o;
    for (int i = 7; i >= 0; i--) clk_bit(v[i], l, o);
    clk_bit(1'b1, l, ack_oe);
  endtask
  task automatic read_byte(output logic [7:0] oev);
    logic l, o;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, l, o);
      oev[i] = o;
    end
  endtask
  task automatic i2c_start;
    hold(H);
    sda_m = 1'b0;
    hold(H);
    scl = 1'b0;
  endtask
  task automatic i2c_rstart;
    hold(H/2);
    sda_m = 1'b1;
    hold(H/2);
    scl = 1'b1;
    hold(H/2);
    sda_m = 1'b0;
    hold(H/2);
    scl = 1'b0;
  endtask
  task automatic i2c_stop;
    hold(H/2);
    sda_m = 1'b0;
    hold(H/2);
    scl = 1'b1;
    hold(H);
    sda_m = 1'b1;
    hold(H);
  endtask
  task automatic test_reset;
    total++;
    if ({bus.sda_oe, bus.rx_data, bus.rx_valid, bus.tx_load, bus.rw, bus.busy, bus.start_det, bus.stop_det} !== 15'h0) begin
      bad++;
      $display("FAIL reset_outputs: got oe=%b rx=%h busy=%b rw=%b want all zero", bus.sda_oe, bus.rx_data, bus.busy, bus.rw);
    end
    total++;
    if (dut.state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
  endtask
  task automatic test_write;
    int r0, s0, p0;
    logic a;
    r0 = rxv_cnt; s0 = sd_cnt; p0 = pd_cnt;
    i2c_start;
    total++;
    if (sd_cnt - s0 != 1 || bus.busy !== 1'b1) begin bad++; $display("FAIL wr_start: got starts=%0d busy=%b want 1 1", sd_cnt - s0, bus.busy); end
    send_byte(8'hA0, a);
    total++;
    if (a !== 1'b1) begin bad++; $display("FAIL wr_addr_ack: got oe=%b want 1", a); end
    total++;
    if (bus.rw !== 1'b0) begin bad++; $display("FAIL wr_rw: got %b want 0", bus.rw); end
    send_byte(8'h3C, a);
    total++;
    if (a !== 1'b1) begin bad++; $display("FAIL wr_data_ack: got oe=%b want 1", a); end
    i2c_stop;
    total++;
    if (rxv_cnt - r0 != 1 || rx_log[r0] !== 8'h3C) begin bad++; $display("FAIL wr_rx: got n=%0d data=%h want 1 3c", rxv_cnt - r0, rx_log[r0]); end
    total++;
    if (bus.rx_data !== 8'h3C) begin bad++; $display("FAIL wr_rx_hold: got %h want 3c", bus.rx_data); end
    total++;
    if (pd_cnt - p0 != 1 || bus.busy !== 1'b0) begin bad++; $display("FAIL wr_stop: got stops=%0d busy=%b want 1 0", pd_cnt - p0, bus.busy); end
  endtask
  task automatic test_wrong_addr;
    int r0, o0;
    logic a;
    r0 = rxv_cnt; o0 = oe_cnt;
    i2c_start;
    send_byte(8'hA4, a);
    total++;
    if (a !== 1'b0) begin bad++; $display("FAIL na_ack: got oe=%b want 0", a); end
    send_byte(8'h11, a);
    total++;
    if (dut.state !== WAIT) begin bad++; $display("FAIL na_wait: got %0d want %0d", dut.state, WAIT); end
    total++;
    if (oe_cnt != o0 || rxv_cnt != r0) begin bad++; $display("FAIL na_quiet: got oe_cycles=%0d rxv=%0d want 0 0", oe_cnt - o0, rxv_cnt - r0); end
    i2c_stop;
    total++;
    if (dut.state !== IDLE) begin bad++; $display("FAIL na_idle: got %0d want %0d", dut.state, IDLE); end
  endtask
  task automatic test_read;
    int t0;
    logic a, l, o;
    logic [7:0] v;
    t0 = txl_cnt;
    bus.tx_data = 8'h96;
    i2c_start;
    send_byte(8'hA1, a);
    total++;
    if (a !== 1'b1 || bus.rw !== 1'b1) begin bad++; $display("FAIL rd_addr: got ack=%b rw=%b want 1 1", a, bus.rw); end
    read_byte(v);
    total++;
    if (v !== 8'h69) begin bad++; $display("FAIL rd_byte1: got oe=%b want 01101001", v); end
    bus.tx_data = 8'h5A;
    clk_bit(1'b0, l, o);
    total++;
    if (o !== 1'b0) begin bad++; $display("FAIL rd_ack_release: got oe=%b want 0", o); end
    read_byte(v);
    total++;
    if (v !== 8'hA5) begin bad++; $display("FAIL rd_byte2: got oe=%b want 10100101", v); end
    clk_bit(1'b1, l, o);
    hold(4);
    total++;
    if (dut.state !== WAIT || bus.sda_oe !== 1'b0) begin bad++; $display("FAIL rd_nack: got state=%0d oe=%b want %0d 0", dut.state, bus.sda_oe, WAIT); end
    total++;
    if (txl_cnt - t0 != 2) begin bad++; $display("FAIL rd_txload: got %0d want 2", txl_cnt - t0); end
    i2c_stop;
  endtask
  task automatic test_rep_start;
    int r0, s0;
    logic a, l, o;
    bus.tx_data = 8'hFF;
    i2c_start;
    send_byte(8'hA0, a);
    r0 = rxv_cnt; s0 = sd_cnt;
    clk_bit(1'b1, l, o);
    clk_bit(1'b0, l, o);
    clk_bit(1'b1, l, o);
    clk_bit(1'b1, l, o);
    i2c_rstart;
    total++;
    if (sd_cnt - s0 != 1 || rxv_cnt != r0) begin bad++; $display("FAIL rs_det: got starts=%0d rxv=%0d want 1 0", sd_cnt - s0, rxv_cnt - r0); end
    send_byte(8'hA1, a);
    total++;
    if (a !== 1'b1 || bus.rw !== 1'b1) begin bad++; $display("FAIL rs_addr: got ack=%b rw=%b want 1 1", a, bus.rw); end
    i2c_stop;
  endtask
  task automatic test_reset_mid_ack;
    logic a, l, o;
    i2c_start;
    send_byte(8'hA0, a);
    for (int i = 7; i >= 0; i--) clk_bit(i[0], l, o);
    hold(H/2);
    sda_m = 1'b1;
    hold(H/2);
    scl = 1'b1;
    hold(H/2);
    total++;
    if (bus.sda_oe !== 1'b1 || dut.state !== RX_ACK) begin bad++; $display("FAIL ra_pre: got oe=%b state=%0d want 1 %0d", bus.sda_oe, dut.state, RX_ACK); end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.sda_oe !== 1'b0) begin bad++; $display("FAIL ra_async: got oe=%b want 0", bus.sda_oe); end
    total++;
    if ({bus.rx_data, bus.rx_valid, bus.tx_load, bus.rw, bus.busy, bus.start_det, bus.stop_det} !== 14'h0 || dut.state !== IDLE) begin
      bad++;
      $display("FAIL ra_values: got rx=%h busy=%b state=%0d want 00 0 %0d", bus.rx_data, bus.busy, dut.state, IDLE);
    end
    hold(2);
    rst_n = 1'b1;
    hold(H);
    scl = 1'b0;
    i2c_stop;
    i2c_start;
    send_byte(8'hA0, a);
    total++;
    if (a !== 1'b1) begin bad++; $display("FAIL ra_restart_ack: got oe=%b want 1", a); end
    send_byte(8'h77, a);
    total++;
    if (bus.rx_data !== 8'h77) begin bad++; $display("FAIL ra_restart_rx: got %h want 77", bus.rx_data); end
    i2c_stop;
  endtask
  task automatic test_back_to_back;
    int r0;
    logic a;
    r0 = rxv_cnt;
    i2c_start;
    send_byte(8'hA0, a);
    send_byte(8'h01, a);
    send_byte(8'h02, a);
    send_byte(8'h03, a);
    i2c_stop;
    total++;
    if (rxv_cnt - r0 != 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", rxv_cnt - r0); end
    else begin
      total++;
      if ({rx_log[r0], rx_log[r0+1], rx_log[r0+2]} !== 24'h010203) begin
        bad++;
        $display("FAIL b2b_data: got %h %h %h want 01 02 03", rx_log[r0], rx_log[r0+1], rx_log[r0+2]);
      end
      total++;
      if (rxv_cyc[r0+1] - rxv_cyc[r0] < 2*H || rxv_cyc[r0+2] - rxv_cyc[r0+1] < 2*H) begin
        bad++;
        $display("FAIL b2b_gap: got %0d %0d want >= %0d", rxv_cyc[r0+1] - rxv_cyc[r0], rxv_cyc[r0+2] - rxv_cyc[r0+1], 2*H);
      end
    end
  endtask
  initial begin
    bus.tx_data = 8'h00;
    hold(5);
    rst_n = 1'b1;
    hold(5);
    test_reset;
    test_write;
    test_wrong_addr;
    test_read;
    test_rep_start;
    test_reset_mid_ack;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
